// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-port signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int log_size   = 10,
  parameter int blocks     = 4,
  parameter int cell_width = 32,
  parameter int width      = cell_width * blocks
);
  logic                in_req0;
  logic                in_req1;
  logic                in_we0;
  logic                in_we1;
  logic [log_size-1:0] in_addr0;
  logic [log_size-1:0] in_addr1;
  logic [width-1:0]    in_wdata0;
  logic [width-1:0]    in_wdata1;
  logic                out_gnt0;
  logic                out_gnt1;
  logic                out_rvalid0;
  logic                out_rvalid1;
  logic [width-1:0]    out_rdata;
  logic                out_err;
  logic [log_size-1:0] out_mem_address;
  logic [width-1:0]    out_mem_data;
  logic                out_mem_read_en;
  logic                out_mem_write_en;
  logic [width-1:0]    in_mem_data;

  modport slave (
    input  in_req0, in_req1, in_we0, in_we1, in_addr0, in_addr1,
           in_wdata0, in_wdata1, in_mem_data,
    output out_gnt0, out_gnt1, out_rvalid0, out_rvalid1, out_rdata, out_err,
           out_mem_address, out_mem_data, out_mem_read_en, out_mem_write_en
  );

  modport master (
    output in_req0, in_req1, in_we0, in_we1, in_addr0, in_addr1,
           in_wdata0, in_wdata1, in_mem_data,
    input  out_gnt0, out_gnt1, out_rvalid0, out_rvalid1, out_rdata, out_err,
           out_mem_address, out_mem_data, out_mem_read_en, out_mem_write_en
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter/sequencer for the single-ported block memory
module mem_arbiter #(
  parameter int log_size   = 10,
  parameter int blocks     = 4,
  parameter int cell_width = 32,
  parameter int width      = cell_width * blocks
) (
  input  logic         in_clk,
  input  logic         in_reset,
  mem_arbiter_if.slave bus
);
  localparam logic [log_size-1:0] low_mask = log_size'(blocks - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic [log_size-1:0] addr_q, addr_d;
  logic [width-1:0]    wdata_q, wdata_d;
  logic                re_q, re_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
  logic [width-1:0]    rdata_q, rdata_d;
  logic                elig0, elig1, win0, win1;

  // A request seen during its own grant cycle is already consumed.
  always_comb begin
    elig0     = bus.in_req0 & (state_q != GRANT0);
    elig1     = bus.in_req1 & (state_q != GRANT1);
    win0      = elig0 & (~elig1 | ~ptr_q);
    win1      = elig1 & (~elig0 | ptr_q);
    state_d   = IDLE;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    re_d      = 1'b0;
    we_d      = 1'b0;
    err_d     = 1'b0;
    if (win0) begin
      state_d = GRANT0;
      ptr_d   = 1'b1;
      addr_d  = bus.in_addr0 & ~low_mask;
      wdata_d = bus.in_wdata0;
      we_d    = bus.in_we0;
      re_d    = ~bus.in_we0;
      err_d   = |(bus.in_addr0 & low_mask);
    end else if (win1) begin
      state_d = GRANT1;
      ptr_d   = 1'b0;
      addr_d  = bus.in_addr1 & ~low_mask;
      wdata_d = bus.in_wdata1;
      we_d    = bus.in_we1;
      re_d    = ~bus.in_we1;
      err_d   = |(bus.in_addr1 & low_mask);
    end
    // Memory data lands one cycle after the read issue; tag it with the issuing requester.
    rvalid0_d = re_q & (state_q == GRANT0);
    rvalid1_d = re_q & (state_q == GRANT1);
    rdata_d   = (rvalid0_q | rvalid1_q) ? bus.in_mem_data : rdata_q;
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      re_q      <= re_d;
      we_q      <= we_d;
      err_q     <= err_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.out_gnt0         = (state_q == GRANT0);
  assign bus.out_gnt1         = (state_q == GRANT1);
  assign bus.out_mem_address  = addr_q;
  assign bus.out_mem_data     = wdata_q;
  assign bus.out_mem_read_en  = re_q;
  assign bus.out_mem_write_en = we_q;
  assign bus.out_err          = err_q;
  assign bus.out_rvalid0      = rvalid0_q;
  assign bus.out_rvalid1      = rvalid1_q;
  // The memory output is only valid in the rvalid cycle, so pass it through then and hold after.
  assign bus.out_rdata        = (rvalid0_q | rvalid1_q) ? bus.in_mem_data : rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a reference arbitration model
module tb_mem_arbiter;
  localparam int log_size = 10;
  localparam int blocks   = 4;
  localparam int width    = 128;
  localparam int nblk     = (1 << log_size) / blocks;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.log_size(log_size), .blocks(blocks), .cell_width(32)) ifc ();
  mem_arbiter #(.log_size(log_size), .blocks(blocks), .cell_width(32)) dut (
    .in_clk  (clk),
    .in_reset(rst),
    .bus     (ifc)
  );

  // Environment memory: registered read port, like the real block memory.
  logic [width-1:0] env_mem [nblk];
  logic [width-1:0] mem_q;
  assign ifc.in_mem_data = mem_q;
  always @(posedge clk) begin
    if (ifc.out_mem_write_en) env_mem[ifc.out_mem_address / blocks] <= ifc.out_mem_data;
    if (ifc.out_mem_read_en) mem_q <= env_mem[ifc.out_mem_address / blocks];
  end

  // Reference model: expected outputs for the cycle after each edge.
  logic [width-1:0] model_mem [nblk];
  bit               m_g [2]  = '{0, 0};
  bit               m_rv [2] = '{0, 0};
  int               m_ptr = 0;
  int               m_addr = 0;
  logic [width-1:0] m_data = '0;
  logic [width-1:0] m_rdata = '0;
  bit               m_re = 0, m_we = 0, m_err = 0;

  always @(posedge clk) begin
    bit               rq [2];
    bit               wq [2];
    int               aq [2];
    logic [width-1:0] dq [2];
    bit               el [2];
    int               win;
    if (rst) begin
      m_g = '{0, 0}; m_rv = '{0, 0}; m_ptr = 0; m_addr = 0;
      m_data = '0; m_rdata = '0; m_re = 0; m_we = 0; m_err = 0;
    end else begin
      if (m_we) model_mem[m_addr / blocks] = m_data;
      m_rv[0] = m_re && m_g[0];
      m_rv[1] = m_re && m_g[1];
      if (m_re) m_rdata = model_mem[m_addr / blocks];
      rq = '{ifc.in_req0, ifc.in_req1};
      wq = '{ifc.in_we0, ifc.in_we1};
      aq = '{int'(ifc.in_addr0), int'(ifc.in_addr1)};
      dq = '{ifc.in_wdata0, ifc.in_wdata1};
      el[0] = rq[0] && !m_g[0];
      el[1] = rq[1] && !m_g[1];
      win = -1;
      if (el[0] && el[1]) win = m_ptr;
      else if (el[0]) win = 0;
      else if (el[1]) win = 1;
      m_g = '{0, 0}; m_re = 0; m_we = 0; m_err = 0;
      if (win >= 0) begin
        m_g[win] = 1;
        m_ptr    = 1 - win;
        m_addr   = (aq[win] / blocks) * blocks;
        m_data   = dq[win];
        m_we     = wq[win];
        m_re     = !wq[win];
        m_err    = (aq[win] % blocks) != 0;
      end
    end
  end

  task automatic chk(input string name, input logic [width-1:0] act, input logic [width-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("gnt0", width'(ifc.out_gnt0), width'(m_g[0]));
    chk("gnt1", width'(ifc.out_gnt1), width'(m_g[1]));
    chk("rvalid0", width'(ifc.out_rvalid0), width'(m_rv[0]));
    chk("rvalid1", width'(ifc.out_rvalid1), width'(m_rv[1]));
    chk("rdata", ifc.out_rdata, m_rdata);
    chk("err", width'(ifc.out_err), width'(m_err));
    chk("mem_address", width'(ifc.out_mem_address), width'(m_addr));
    chk("mem_data", ifc.out_mem_data, m_data);
    chk("mem_read_en", width'(ifc.out_mem_read_en), width'(m_re));
    chk("mem_write_en", width'(ifc.out_mem_write_en), width'(m_we));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [width-1:0] wval = 128'h44444444_33333333_22222222_11111111;
  int c0, c1;

  initial begin
    for (int i = 0; i < nblk; i++) begin
      env_mem[i]   = {4{32'hC0DE0000 + 32'(i)}};
      model_mem[i] = {4{32'hC0DE0000 + 32'(i)}};
    end
    mem_q = '0;
    rst = 1'b1;
    ifc.in_req0 = 1'b1; ifc.in_we0 = 1'b0; ifc.in_addr0 = '0; ifc.in_wdata0 = '0;
    ifc.in_req1 = 1'b0; ifc.in_we1 = 1'b0; ifc.in_addr1 = '0; ifc.in_wdata1 = '0;

    // Reset with a pending request: nothing issued.
    step();
    chk("rst_gnt0", width'(ifc.out_gnt0), '0);
    chk("rst_rdata", ifc.out_rdata, '0);
    chk("rst_en", width'({ifc.out_mem_read_en, ifc.out_mem_write_en}), '0);
    rst = 1'b0;
    step();
    chk("first_gnt0", width'(ifc.out_gnt0), width'(1));
    ifc.in_req0 = 1'b0;
    step();
    chk("first_rvalid0", width'(ifc.out_rvalid0), width'(1));
    chk("first_rdata", ifc.out_rdata, {4{32'hC0DE0000}});

    // Write then read on requester 0.
    ifc.in_req0 = 1'b1; ifc.in_we0 = 1'b1; ifc.in_addr0 = 10'h008; ifc.in_wdata0 = wval;
    step();
    chk("wr_gnt0", width'(ifc.out_gnt0), width'(1));
    chk("wr_we", width'(ifc.out_mem_write_en), width'(1));
    chk("wr_addr", width'(ifc.out_mem_address), width'(10'h008));
    ifc.in_req0 = 1'b0;
    step();
    ifc.in_req0 = 1'b1; ifc.in_we0 = 1'b0;
    step();
    chk("rd_re", width'(ifc.out_mem_read_en), width'(1));
    ifc.in_req0 = 1'b0;
    step();
    chk("rd_rvalid0", width'(ifc.out_rvalid0), width'(1));
    chk("rd_rdata", ifc.out_rdata, wval);
    step();
    chk("rd_hold", ifc.out_rdata, wval);

    // Tie after reset, then sustained contention.
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifc.in_req0 = 1'b1; ifc.in_we0 = 1'b0; ifc.in_addr0 = 10'h000;
    ifc.in_req1 = 1'b1; ifc.in_we1 = 1'b0; ifc.in_addr1 = 10'h004;
    step();
    chk("tie_gnt0", width'({ifc.out_gnt1, ifc.out_gnt0}), width'(2'b01));
    step();
    chk("tie_gnt1", width'({ifc.out_gnt1, ifc.out_gnt0}), width'(2'b10));
    chk("tie_rvalid0", width'(ifc.out_rvalid0), width'(1));
    c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      c0 += int'(ifc.out_gnt0);
      c1 += int'(ifc.out_gnt1);
    end
    chk("cont_cnt0", width'(c0), width'(4));
    chk("cont_cnt1", width'(c1), width'(4));
    ifc.in_req0 = 1'b0; ifc.in_req1 = 1'b0;
    step();
    step();

    // Held request on requester 1.
    ifc.in_req1 = 1'b1; ifc.in_addr1 = 10'h010;
    c1 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      c1 += int'(ifc.out_gnt1);
    end
    chk("held_cnt1", width'(c1), width'(3));
    ifc.in_req1 = 1'b0;
    step();
    step();

    // Misaligned read completes normally.
    ifc.in_req1 = 1'b1; ifc.in_addr1 = 10'h00B;
    step();
    chk("mis_addr", width'(ifc.out_mem_address), width'(10'h008));
    chk("mis_err", width'(ifc.out_err), width'(1));
    ifc.in_req1 = 1'b0;
    step();
    chk("mis_err_once", width'(ifc.out_err), '0);
    chk("mis_rvalid1", width'(ifc.out_rvalid1), width'(1));
    chk("mis_rdata", ifc.out_rdata, wval);
    step();

    // Misaligned read cut short by reset before its data returns.
    ifc.in_req0 = 1'b1; ifc.in_addr0 = 10'h00B;
    step();
    chk("mis2_err", width'(ifc.out_err), width'(1));
    ifc.in_req0 = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_drop_rvalid0", width'(ifc.out_rvalid0), '0);
    rst = 1'b0;
    step();
    chk("rst_drop_later", width'(ifc.out_rvalid0), '0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
